spi_regbank_burst: RTL
======================

SPI_REGBANK_BURST -- requirements
Module: spi_regbank_burst

Interface
REQ-001 SHALL have parameter NUM_CFG, default 8: number of read/write config registers.
REQ-002 SHALL have parameter NUM_STAT, default 8: number of read-only status registers.
REQ-003 SHALL have parameter WIDTH, default 8: register width in bits; legal range 8..32.
REQ-004 SHALL have parameter CPOL, default 0: SCLK idle level; sampling is always on the leading edge (CPHA=0).
REQ-005 SHALL support only configurations with NUM_CFG+NUM_STAT <= 128 (7-bit address).
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ena  input  1  block enable; when low, SPI traffic is ignored.
REQ-009 spi_cs_n  input  1  chip select, active low, asynchronous to clk.
REQ-010 spi_clk  input  1  SPI clock, asynchronous to clk.
REQ-011 spi_mosi  input  1  serial data in, MSB first.
REQ-012 spi_miso  output  1  serial data out, MSB first.
REQ-013 spi_miso_oe  output  1  high while a read data phase is active.
REQ-014 stat_regs  input  NUM_STAT*WIDTH  status words, register k at bits [k*WIDTH +: WIDTH].
REQ-015 config_regs  output  NUM_CFG*WIDTH  config words, same packing.
REQ-016 wr_pulse  output  1  one-clk strobe on each completed config write.
REQ-017 wr_addr  output  7  address of the last completed config write.

Function
REQ-018 SHALL pass spi_cs_n, spi_clk and spi_mosi through 2-flop synchronisers; edges are detected on the synchronised values; clk SHALL be >= 4x SCLK.
REQ-019 Leading edge = rising for CPOL=0, falling for CPOL=1; MOSI sampled on leading edges, MISO changed on trailing edges.
REQ-020 FSM states: IDLE, CMD, DATA; IDLE->CMD on synchronised CS falling edge while ena=1.
REQ-021 CMD: shift 8 bits; bit7=1 write, 0 read; bits[6:0]=start address; after 8th leading edge -> DATA.
REQ-022 DATA: each WIDTH leading edges form one word; frame continues in DATA until CS rises (burst).
REQ-023 Address auto-increments after every completed word, wrapping from NUM_CFG+NUM_STAT-1 to 0.
REQ-024 Map: 0..NUM_CFG-1 config (RW); NUM_CFG..NUM_CFG+NUM_STAT-1 status (RO); higher addresses reserved.
REQ-025 Write word to config address: register updated and wr_pulse=1, wr_addr=address, on the clk after the word's last sampling edge is detected.
REQ-026 Write to status or reserved address: discarded, no wr_pulse, address still increments.
REQ-027 Read: word loaded into TX shifter on the clk that completes the command byte, and for burst on the clk completing each data word; status snapshot taken at load time.
REQ-028 Read of reserved address returns all zeros.
REQ-029 spi_miso = TX MSB; TX shifts on every trailing edge in DATA except the first trailing edge after a load.
REQ-030 spi_miso and spi_miso_oe SHALL be 0 outside a read DATA phase.
REQ-031 CS rise in any state -> IDLE next clk; partial command or word discarded, no write.
REQ-032 ena low during a frame -> IDLE, same as REQ-031; ena rising mid-frame waits for the next CS falling edge.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, config_regs=0, wr_pulse=0, wr_addr=0, spi_miso=0, spi_miso_oe=0, shifters/counters cleared.
REQ-034 Reset mid-frame SHALL abort the frame; no partial write survives; the next transaction requires a fresh CS falling edge.

Verification
REQ-035 Single write: cmd 0x83, data 0xA5 -> config reg 3 = 0xA5, one wr_pulse, wr_addr=3.
REQ-036 Burst write: cmd 0x86, data 0x11,0x22,0x33 (NUM_CFG=NUM_STAT=8) -> cfg6=0x11, cfg7=0x22, status addr 8 unchanged, exactly two wr_pulses.
REQ-037 Burst read across wrap: stat15=0x5A, cfg0=0xC3, cmd 0x0F, read 2 words -> MISO returns 0x5A then 0xC3, spi_miso_oe high only in DATA.
REQ-038 Abort: cmd 0x82, 5 data bits then CS rise -> cfg2 unchanged, no wr_pulse, next full frame works.
REQ-039 Reset mid-burst after cfg1 written: rst pulse -> all config_regs 0, outputs 0; subsequent read of addr 1 returns 0x00.
REQ-040 CPOL=1, WIDTH=16 build: write 0x1234 to addr 0, read back -> 0x1234.

Source files
------------

// File: rtl/spi_regbank_burst.sv
`timescale 1ns/1ps
// SPI slave register bank: config (RW) and status (RO) words behind a 7-bit address,
// command byte followed by a burst of data words with address auto-increment.
module spi_regbank_burst #(
    parameter int NUM_CFG  = 8,
    parameter int NUM_STAT = 8,
    parameter int WIDTH    = 8,
    parameter int CPOL     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      spi_cs_n,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    input  logic [NUM_STAT*WIDTH-1:0] stat_regs,
    output logic [NUM_CFG*WIDTH-1:0]  config_regs,
    output logic                      wr_pulse,
    output logic [6:0]                wr_addr
);

    // state | meaning
    // IDLE  | waiting for a CS falling edge while enabled
    // CMD   | shifting in the command byte (rw bit + start address)
    // DATA  | shifting data words, burst continues until CS rises

    localparam int         TOTAL     = NUM_CFG + NUM_STAT;
    localparam logic [6:0] LAST_ADDR = 7'(TOTAL - 1);
    localparam logic [4:0] WORD_LAST = 5'(WIDTH - 1);
    localparam logic       CPOL_BIT  = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    state_t state_q, state_d;

    logic [2:0]       cs_sync, sclk_sync;
    logic [1:0]       mosi_sync;
    logic [4:0]       bit_cnt;
    logic [WIDTH-2:0] rx_sh;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] cfg_q [NUM_CFG];
    logic [WIDTH-1:0] rd_word, word;
    logic [6:0]       addr_q, addr_inc, rd_addr;
    logic [7:0]       cmd_byte;
    logic             skip_q, is_wr;
    logic             mosi_s, cs_fall, cs_high, sclk_rise, sclk_fall, lead, trail, abort;
    logic             cmd_done, word_done, shift_en, cfg_hit;

    // CS synchroniser resets low so a reset during a frame never fakes a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= 3'b000;
            sclk_sync <= {3{CPOL_BIT}};
            mosi_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_sync[2] & ~cs_sync[1];
    assign cs_high   = cs_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    assign lead      = CPOL_BIT ? sclk_fall : sclk_rise;
    assign trail     = CPOL_BIT ? sclk_rise : sclk_fall;
    assign abort     = cs_high | ~ena;

    assign cmd_byte = {rx_sh[6:0], mosi_s};
    assign word     = {rx_sh, mosi_s};
    assign addr_inc = (addr_q == LAST_ADDR) ? 7'd0 : addr_q + 7'd1;
    assign rd_addr  = (state_q == CMD) ? cmd_byte[6:0] : addr_inc;
    assign cfg_hit  = ({1'b0, addr_q} < 8'(NUM_CFG));
    assign shift_en = lead && !abort && (state_q != IDLE);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_CFG; k++)
            if (rd_addr == 7'(k)) rd_word = cfg_q[k];
        for (int k = 0; k < NUM_STAT; k++)
            if (rd_addr == 7'(NUM_CFG + k)) rd_word = stat_regs[k*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        unique case (state_q)
            IDLE: if (ena && cs_fall) state_d = CMD;
            CMD: begin
                if (abort) state_d = IDLE;
                else if (lead && bit_cnt == 5'd0) begin
                    cmd_done = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (abort) state_d = IDLE;
                else if (lead && bit_cnt == 5'd0) word_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bit_cnt  <= 5'd0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            skip_q   <= 1'b0;
            is_wr    <= 1'b0;
            addr_q   <= 7'd0;
            wr_pulse <= 1'b0;
            wr_addr  <= 7'd0;
            for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            wr_pulse <= 1'b0;
            if (state_q == IDLE) begin
                bit_cnt <= 5'd7;
                tx_sh   <= '0;
                skip_q  <= 1'b0;
            end
            if (shift_en) begin
                rx_sh   <= word[WIDTH-2:0];
                bit_cnt <= bit_cnt - 5'd1;
            end
            if (cmd_done) begin
                is_wr   <= cmd_byte[7];
                addr_q  <= cmd_byte[6:0];
                bit_cnt <= WORD_LAST;
                tx_sh   <= rd_word;
                skip_q  <= 1'b1;
            end
            if (word_done) begin
                addr_q  <= addr_inc;
                bit_cnt <= WORD_LAST;
                if (is_wr) begin
                    if (cfg_hit) begin
                        wr_pulse <= 1'b1;
                        wr_addr  <= addr_q;
                    end
                end else begin
                    tx_sh  <= rd_word;
                    skip_q <= 1'b1;
                end
            end
            // a freshly loaded word holds its MSB through the first trailing edge
            if (trail && !abort && state_q == DATA) begin
                if (skip_q) skip_q <= 1'b0;
                else        tx_sh  <= tx_sh << 1;
            end
            for (int k = 0; k < NUM_CFG; k++)
                if (word_done && is_wr && addr_q == 7'(k)) cfg_q[k] <= word;
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign config_regs[g*WIDTH +: WIDTH] = cfg_q[g];
    end

    assign spi_miso_oe = (state_q == DATA) && !is_wr;
    assign spi_miso    = spi_miso_oe & tx_sh[WIDTH-1];

endmodule
